// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage RV32 instruction word encoder with range check and error counter
module instr_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           imm_sel,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        s1_valid;
    logic        s1_err;
    logic [2:0]  s1_sel;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [31:0] s1_imm;

    logic        s2_adv;
    logic        accept;
    logic        in_range;
    logic [31:0] packed_word;
    logic signed [31:0] simm;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;
    assign simm     = imm;

    // Range check runs on the raw request so S1 only stores a single error bit.
    always_comb begin
        in_range = 1'b0;
        case (imm_sel)
            3'd0, 3'd1: in_range = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            3'd2:       in_range = !imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
            3'd3:       in_range = (imm[11:0] == 12'd0);
            3'd4:       in_range = !imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
            default:    in_range = 1'b0;
        endcase
    end

    always_comb begin
        packed_word = NOP;
        case (s1_sel)
            3'd0: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            3'd1: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            3'd2: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                 s1_imm[4:1], s1_imm[11], s1_opcode};
            3'd3: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
            3'd4: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                 s1_rd, s1_opcode};
            default: packed_word = NOP;
        endcase
        if (s1_err) begin
            packed_word = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (out_valid && out_ready && out_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= packed_word;
                    out_err   <= s1_err;
                end
            end
            // in_ready already folds in "S1 empty or S1 moving on".
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_err    <= !in_range;
                s1_sel    <= imm_sel;
                s1_opcode <= opcode;
                s1_rd     <= rd;
                s1_rs1    <= rs1;
                s1_rs2    <= rs2;
                s1_funct3 <= funct3;
                s1_imm    <= imm;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with random jobs and reference model
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_sel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    instr_encoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t  q[$];
    int    pop_cyc[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    m_err = 0;
    bit    rand_ready = 0;
    bit    held_v = 0;
    logic [31:0] held_instr;
    logic        held_err;
    exp_t  e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    function automatic logic [32:0] model(input logic [2:0] sel, input logic [6:0] op,
                                          input logic [4:0] d, input logic [4:0] a,
                                          input logic [4:0] b, input logic [2:0] f3,
                                          input logic [31:0] im);
        longint v;
        bit ok;
        logic [31:0] w;
        v = longint'($signed(im));
        ok = 0;
        w = 32'd0;
        case (sel)
            3'd0: begin ok = v >= -2048 && v <= 2047; w = {im[11:0], a, f3, d, op}; end
            3'd1: begin ok = v >= -2048 && v <= 2047; w = {im[11:5], b, a, f3, im[4:0], op}; end
            3'd2: begin
                ok = (v % 2 == 0) && v >= -4096 && v <= 4094;
                w = {im[12], im[10:5], b, a, f3, im[4:1], im[11], op};
            end
            3'd3: begin ok = (im % 4096) == 0; w = {im[31:12], d, op}; end
            3'd4: begin
                ok = (v % 2 == 0) && v >= -1048576 && v <= 1048574;
                w = {im[20], im[10:1], im[11], im[19:12], d, op};
            end
            default: ok = 0;
        endcase
        if (!ok) return {1'b1, 32'h0000_0013};
        return {1'b0, w};
    endfunction

    task automatic scramble_idle();
        imm_sel = 3'($urandom); opcode = 7'($urandom); rd = 5'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom); imm = $urandom;
    endtask

    task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                        input logic [31:0] im, input logic [31:0] ex_instr, input logic ex_err,
                        input bit lat);
        bit ok;
        int acc;
        exp_t x;
        imm_sel = sel; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; imm = im;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            acc = cyc;
            @(posedge clk);
            #1;
        end
        if (ok) begin
            x.instr = ex_instr; x.err = ex_err; x.acc = acc; x.lat = lat;
            q.push_back(x);
        end else begin
            chk("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        scramble_idle();
    endtask

    task automatic send_model(input logic [2:0] sel, input logic [6:0] op, input logic [31:0] im,
                              input bit lat);
        logic [4:0] d, a, b;
        logic [2:0] f3;
        logic [32:0] r;
        d = 5'($urandom); a = 5'($urandom); b = 5'($urandom); f3 = 3'($urandom);
        r = model(sel, op, d, a, b, f3, im);
        send(sel, op, d, a, b, f3, im, r[31:0], r[32], lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            m_err = 0;
            held_v = 0;
        end else begin
            chk("err_count", err_count, m_err);
            if (held_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_instr", out_instr, held_instr);
                chk("hold_err", out_err, held_err);
            end
            held_v = 0;
            if (out_valid && !out_ready) begin
                held_v = 1;
                held_instr = out_instr;
                held_err = out_err;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", out_instr, 32'hxxxxxxxx);
                end else begin
                    e = q.pop_front();
                    chk("out_instr", out_instr, e.instr);
                    chk("out_err", out_err, e.err);
                    if (e.lat) chk("latency", cyc - e.acc, 2);
                    pop_cyc.push_back(cyc);
                    if (e.err && m_err < 255) m_err = m_err + 1;
                end
            end
        end
    end

    int bnd[18] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097, 4096,
                    -1048576, 1048574, 1048576, -1048578, 1, 3, -2, 0, 1048575};

    initial begin
        logic [31:0] im;
        logic [2:0]  sel;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        scramble_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);

        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, -32'sd5,   32'hFFB10093, 1'b0, 1);
        send(3'd1, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, -32'sd64,  32'hFC112023, 1'b0, 1);
        send(3'd3, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'hABCD0000, 32'hABCD00B7, 1'b0, 1);
        send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8,     32'h00208463, 1'b0, 1);
        send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd56,  32'hFC9FF0EF, 1'b0, 1);
        send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3,     32'h00000013, 1'b1, 1);
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048,  32'h00000013, 1'b1, 1);
        send(3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd0,     32'h00000013, 1'b1, 1);
        drain();
        chk("three_errors", err_count, 3);

        // Backpressure: two jobs fill the pipe, the third waits until the consumer frees it.
        out_ready = 1'b0;
        pop_cyc.delete();
        send_model(3'd0, 7'h13, 32'd100, 0);
        send_model(3'd1, 7'h23, -32'sd7, 0);
        fork
            send_model(3'd3, 7'h37, 32'h12345000, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("bp_gap0", pop_cyc[1] - pop_cyc[0], 1);
            chk("bp_gap1", pop_cyc[2] - pop_cyc[1], 1);
        end

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            sel = ($urandom % 8 < 6) ? 3'($urandom % 5) : 3'($urandom);
            case ($urandom % 4)
                0: im = 32'($signed($urandom_range(0, 6000)) - 3000);
                1: im = 32'(bnd[$urandom % 18]);
                2: im = $urandom;
                default: im = $urandom & 32'hFFFFF000;
            endcase
            send_model(sel, 7'($urandom), im, 0);
            repeat ($urandom % 3) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Reset while S2 holds an errored job and S1 holds another.
        out_ready = 1'b0;
        send(3'd5, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h00000013, 1'b1, 0);
        send_model(3'd0, 7'h13, 32'd7, 0);
        @(negedge clk);
        chk("mid_out_valid", out_valid, 1);
        chk("mid_s1_full", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_blocks_in_ready", in_ready, 0);
        q.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_out_instr", out_instr, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("mid_post_in_ready", in_ready, 1);
        send_model(3'd2, 7'h63, -32'sd20, 1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        drain();

        for (int i = 0; i < 262; i++) begin
            send(3'd6, 7'($urandom), 5'd0, 5'd0, 5'd0, 3'd0, $urandom, 32'h00000013, 1'b1, 0);
        end
        drain();
        chk("err_saturate", err_count, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
